car_seq_predictor: RTL and testbench

Golden reference model for the car-park sensor counter in the HVM bench. It watches the two beam sensors `a`/`b`, decodes complete entry and exit sequences with a state machine, and emits one-cycle `inc_exp`/`dec_exp` pulses. It also keeps a saturating expected occupancy count. It sits directly upstream of the scoreboard, which consumes these signals and compares them against the DUT's `inc_act`/`dec_act`/`count`.

---
 rtl/car_seq_pkg.sv | 22 ++
 rtl/sat_updown_counter.sv | 28 ++
 rtl/car_seq_predictor.sv | 122 ++++++++++++
 tb/tb_car_seq_predictor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/car_seq_pkg.sv
// car_seq_pkg: shared types and constants for the car-park sequence predictor.
//   seq_state_t : decoder states (3-bit encoding)
//   AB_*        : sensor pair {a,b} encodings
package car_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    ERR  = 3'd7
  } seq_state_t;

  localparam logic [1:0] AB_IDLE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: W-bit up/down counter saturating at 0 and 2^W-1.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   inc   : count up one step (ignored at maximum)
//   dec   : count down one step (ignored at zero)
//   value : current count
// Simultaneous inc and dec leave the value unchanged.
module sat_updown_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (inc && !dec && (value != '1)) begin
      value <= value + W'(1);
    end else if (dec && !inc && (value != '0)) begin
      value <= value - W'(1);
    end
  end

endmodule

// File: rtl/car_seq_predictor.sv
// car_seq_predictor: reference model for the car-park sensor counter.
// Decodes entry/exit sequences on the beam sensors and produces expected
// pulses and counts for the scoreboard.
//   clk       : rising-edge clock
//   reset     : synchronous, active-low
//   a, b      : outer / inner beam sensors (1 = blocked), already synchronous
//   inc_exp   : one-cycle pulse per completed entry
//   dec_exp   : one-cycle pulse per completed exit
//   exp_count : expected occupancy, saturating at 0 and 2^COUNT_W-1
//   proto_err : one-cycle pulse on entry to ERR
//   err_count : protocol error count, saturating at 2^ERR_W-1
module car_seq_predictor
  import car_seq_pkg::*;
#(
  parameter int COUNT_W = 4,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               b,
  output logic               inc_exp,
  output logic               dec_exp,
  output logic [COUNT_W-1:0] exp_count,
  output logic               proto_err,
  output logic [ERR_W-1:0]   err_count
);

  seq_state_t state, state_n;
  logic       inc_n, dec_n, err_n;
  logic [1:0] ab;

  assign ab = {a, b};

  always_comb begin
    state_n = state;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if      (ab == AB_A)    state_n = EN1;
        else if (ab == AB_B)    state_n = EX1;
        else if (ab == AB_BOTH) state_n = ERR;
      end
      EN1: begin
        if      (ab == AB_BOTH) state_n = EN2;
        else if (ab == AB_IDLE) state_n = IDLE;
        else if (ab == AB_B)    state_n = ERR;
      end
      EN2: begin
        if      (ab == AB_B)    state_n = EN3;
        else if (ab == AB_A)    state_n = EN1;
        else if (ab == AB_IDLE) state_n = ERR;
      end
      EN3: begin
        if (ab == AB_IDLE) begin
          state_n = IDLE;
          inc_n   = 1'b1;
        end
        else if (ab == AB_BOTH) state_n = EN2;
        else if (ab == AB_A)    state_n = ERR;
      end
      EX1: begin
        if      (ab == AB_BOTH) state_n = EX2;
        else if (ab == AB_IDLE) state_n = IDLE;
        else if (ab == AB_A)    state_n = ERR;
      end
      EX2: begin
        if      (ab == AB_A)    state_n = EX3;
        else if (ab == AB_B)    state_n = EX1;
        else if (ab == AB_IDLE) state_n = ERR;
      end
      EX3: begin
        if (ab == AB_IDLE) begin
          state_n = IDLE;
          dec_n   = 1'b1;
        end
        else if (ab == AB_BOTH) state_n = EX2;
        else if (ab == AB_B)    state_n = ERR;
      end
      ERR: begin
        if (ab == AB_IDLE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Only the edge into ERR counts as an error, not every cycle spent there.
    err_n = (state_n == ERR) && (state != ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      inc_exp   <= 1'b0;
      dec_exp   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      inc_exp   <= inc_n;
      dec_exp   <= dec_n;
      proto_err <= err_n;
    end
  end

  // Counters consume the same combinational strobes so the new value
  // appears on the same edge as the pulse.
  sat_updown_counter #(.W(COUNT_W)) u_occ_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_n),
    .dec   (dec_n),
    .value (exp_count)
  );

  sat_updown_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_n),
    .dec   (1'b0),
    .value (err_count)
  );

endmodule

// File: tb/tb_car_seq_predictor.sv
module tb_car_seq_predictor;

  localparam int COUNT_W = 4;
  localparam int ERR_W   = 8;
  localparam int CMAX    = (1 << COUNT_W) - 1;
  localparam int EMAX    = (1 << ERR_W) - 1;

  logic               clk;
  logic               reset;
  logic               a, b;
  logic               inc_exp, dec_exp, proto_err;
  logic [COUNT_W-1:0] exp_count;
  logic [ERR_W-1:0]   err_count;

  car_seq_predictor #(.COUNT_W(COUNT_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .inc_exp   (inc_exp),
    .dec_exp   (dec_exp),
    .exp_count (exp_count),
    .proto_err (proto_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a passage is a walk along the 4-step gray path
  // 00 -> first beam -> both -> second beam -> 00. Position along the path
  // is derived from ab for the current direction; single steps move,
  // stepping off the far end completes, anything else is a protocol error.
  int m_dir;   // 0 idle, +1 entering, -1 exiting, 2 error
  int m_pos;
  int m_cnt, m_err;
  bit m_inc, m_dec, m_perr;

  function automatic int path_pos(input int dir, input logic [1:0] v);
    logic [1:0] w;
    w = (dir > 0) ? v : {v[0], v[1]};
    case (w)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_err();
    m_dir  = 2;
    m_perr = 1;
    if (m_err < EMAX) m_err++;
  endtask

  always @(posedge clk) begin
    logic [1:0] v;
    int q, d;
    v = {a, b};
    m_inc = 0; m_dec = 0; m_perr = 0;
    if (!reset) begin
      m_dir = 0; m_pos = 0; m_cnt = 0; m_err = 0;
    end else if (m_dir == 0) begin
      if (v == 2'b10)      begin m_dir = 1;  m_pos = 1; end
      else if (v == 2'b01) begin m_dir = -1; m_pos = 1; end
      else if (v == 2'b11) model_err();
    end else if (m_dir == 2) begin
      if (v == 2'b00) m_dir = 0;
    end else begin
      q = path_pos(m_dir, v);
      d = q - m_pos;
      if (d == 0) begin
      end else if (d == 1 || d == -1) begin
        if (q == 0) m_dir = 0; else m_pos = q;
      end else if (m_pos == 3 && q == 0) begin
        if (m_dir > 0) begin m_inc = 1; if (m_cnt < CMAX) m_cnt++; end
        else           begin m_dec = 1; if (m_cnt > 0)    m_cnt--; end
        m_dir = 0;
      end else begin
        model_err();
      end
    end
  end

  int inc_seen = 0, dec_seen = 0, err_seen = 0;
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("inc_exp",   int'(inc_exp),   int'(m_inc));
      check("dec_exp",   int'(dec_exp),   int'(m_dec));
      check("proto_err", int'(proto_err), int'(m_perr));
      check("exp_count", int'(exp_count), m_cnt);
      check("err_count", int'(err_count), m_err);
      check("inc_dec_exclusive", int'(inc_exp && dec_exp), 0);
      if (inc_exp)   inc_seen++;
      if (dec_exp)   dec_seen++;
      if (proto_err) err_seen++;
    end
  end

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    {a, b} = v;
  endtask

  task automatic settle();
    drive(2'b00);
    @(negedge clk);
    #1;
  endtask

  task automatic entry();
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
  endtask

  task automatic exit_seq();
    drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
  endtask

  initial begin
    reset = 1'b0;
    {a, b} = 2'b00;
    @(posedge clk); @(posedge clk);
    cmp_en = 1;
    #1;
    check("reset_exp_count", int'(exp_count), 0);
    check("reset_err_count", int'(err_count), 0);
    check("reset_inc", int'(inc_exp), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single entry
    drive(2'b00); entry(); settle();
    check("entry1_pulses", inc_seen, 1);
    check("entry1_count", int'(exp_count), 1);
    check("entry1_err", int'(err_count), 0);

    // Exit, then exit again at zero
    exit_seq(); settle();
    check("exit1_pulses", dec_seen, 1);
    check("exit1_count", int'(exp_count), 0);
    exit_seq(); settle();
    check("exit2_pulses", dec_seen, 2);
    check("exit2_count", int'(exp_count), 0);

    // 16 back-to-back entries: saturate at 15
    for (int i = 0; i < 16; i++) entry();
    settle();
    check("burst_pulses", inc_seen, 17);
    check("burst_count", int'(exp_count), CMAX);

    // Car reverses out: no pulse
    drive(2'b10); drive(2'b11); drive(2'b10); drive(2'b00); settle();
    check("reverse_pulses", inc_seen + dec_seen, 19);
    check("reverse_count", int'(exp_count), CMAX);

    // Long holds in mid-sequence do not time out
    drive(2'b10);
    for (int i = 0; i < 20; i++) drive(2'b11);
    drive(2'b01); drive(2'b01); drive(2'b00); settle();
    check("hold_pulses", inc_seen, 18);

    // Protocol error, then a valid entry still counts
    drive(2'b00); drive(2'b11); drive(2'b01); drive(2'b00); settle();
    check("err_pulses", err_seen, 1);
    check("err_count1", int'(err_count), 1);
    check("err_no_inc", inc_seen, 18);
    entry(); settle();
    check("post_err_pulses", inc_seen, 19);

    // Reset while in EN3: sequence aborted, everything cleared
    drive(2'b10); drive(2'b11); drive(2'b01);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; {a, b} = 2'b00;
    settle();
    check("rst_mid_pulses", inc_seen, 19);
    check("rst_mid_count", int'(exp_count), 0);
    check("rst_mid_err", int'(err_count), 0);

    // Reset on the completing edge wins over the pulse
    drive(2'b10); drive(2'b11); drive(2'b01);
    @(negedge clk); reset = 1'b0; {a, b} = 2'b00;
    @(negedge clk); reset = 1'b1;
    settle();
    check("rst_edge_pulses", inc_seen, 19);

    // Exit from idle then a mirrored error (EX1 with 10)
    drive(2'b01); drive(2'b10); drive(2'b00); settle();
    check("ex_err_count", int'(err_count), 1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      drive(2'b11); drive(2'b00);
    end
    settle();
    check("err_sat", int'(err_count), EMAX);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
